// File: rtl/zion_arb_pkg.sv
// Shared arbitration types and helpers for the zion bitmap mux/arbiter family.
package zion_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Binary index of a onehot vector; a zero vector maps to index 0.
    function automatic int onehot2idx(input logic [63:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/zion_rr_onehot_pick.sv
// Combinational onehot pick: first set bit of req at or above ptr, wrapping to bit 0.
module zion_rr_onehot_pick #(
    parameter int CHN   = 4,
    parameter int IDX_W = $clog2(CHN)
) (
    input  logic [CHN-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic [CHN-1:0]   gnt
);

    logic [2*CHN-1:0] dbl;
    logic [2*CHN-1:0] dbl_m;
    logic [2*CHN-1:0] low;

    // The upper copy keeps every bit, so bits below ptr are still reachable after the wrap.
    always_comb begin
        dbl = {req, req};
        for (int j = 0; j < 2 * CHN; j++) begin
            dbl_m[j] = dbl[j] & (j >= int'(ptr));
        end
        low = dbl_m & (~dbl_m + (2*CHN)'(1));
        gnt = low[CHN-1:0] | low[2*CHN-1:CHN];
    end

endmodule

// File: rtl/zion_mux_bitmap_arb.sv
// Registered N-channel bitmap mux with fixed-LSB or round-robin arbitration
// feeding a one-entry valid/ready output register.
module zion_mux_bitmap_arb
    import zion_arb_pkg::*;
#(
    parameter int        CHN   = 4,
    parameter int        WIDTH = 8,
    parameter arb_mode_e MODE  = ARB_FIXED,
    parameter int        IDX_W = $clog2(CHN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHN-1:0]       iVld,
    input  logic [CHN*WIDTH-1:0] iDat,
    input  logic [CHN-1:0]       iMask,
    output logic [CHN-1:0]       oRdy,
    output logic                 oVld,
    output logic [WIDTH-1:0]     oDat,
    output logic [CHN-1:0]       oSel,
    output logic [IDX_W-1:0]     oIdx,
    input  logic                 iRdy
);

    initial begin
        if (CHN < 2 || WIDTH < 1) begin
            $error("zion_mux_bitmap_arb: illegal parameters CHN=%0d WIDTH=%0d", CHN, WIDTH);
`ifdef CHECK_ERR_EXIT
            $finish;
`endif
        end
    end

    logic [CHN-1:0]   req;
    logic [CHN-1:0]   gnt;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] gidx;
    logic             load;

    logic             oVld_q, oVld_d;
    logic [WIDTH-1:0] oDat_q, oDat_d;
    logic [CHN-1:0]   oSel_q, oSel_d;
    logic [IDX_W-1:0] oIdx_q, oIdx_d;
    logic [IDX_W-1:0] ptr_q,  ptr_d;

    assign req      = iVld & iMask;
    assign pick_ptr = (MODE == ARB_RR) ? ptr_q : '0;

    zion_rr_onehot_pick #(
        .CHN   (CHN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (pick_ptr),
        .gnt (gnt)
    );

    assign gidx = IDX_W'(onehot2idx(64'(gnt)));
    assign load = ~oVld_q | iRdy;
    assign oRdy = rst ? '0 : (gnt & {CHN{load}});

    always_comb begin
        oVld_d = oVld_q;
        oDat_d = oDat_q;
        oSel_d = oSel_q;
        oIdx_d = oIdx_q;
        ptr_d  = ptr_q;
        if (load) begin
            if (|req) begin
                oVld_d = 1'b1;
                oDat_d = iDat[int'(gidx)*WIDTH +: WIDTH];
                oSel_d = gnt;
                oIdx_d = gidx;
            end else begin
                oVld_d = 1'b0;
            end
        end
        // Only an actual transfer advances the turn; idle or masked channels never consume one.
        if (|oRdy) begin
            ptr_d = (gidx == IDX_W'(CHN - 1)) ? '0 : gidx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oVld_q <= 1'b0;
            oDat_q <= '0;
            oSel_q <= '0;
            oIdx_q <= '0;
            ptr_q  <= '0;
        end else begin
            oVld_q <= oVld_d;
            oDat_q <= oDat_d;
            oSel_q <= oSel_d;
            oIdx_q <= oIdx_d;
            ptr_q  <= ptr_d;
        end
    end

    assign oVld = oVld_q;
    assign oDat = oDat_q;
    assign oSel = oSel_q;
    assign oIdx = oIdx_q;

endmodule

`ifndef ZION_MUX_BITMAP_ARB_MACRO
`define ZION_MUX_BITMAP_ARB_MACRO
`define Zion_mux_bitmap_arb(UnitName, clk_, rst_, iVld_, iDat_, iMask_, oRdy_, oVld_, oDat_, oSel_, oIdx_, iRdy_, MODE_ = zion_arb_pkg::ARB_FIXED) \
    zion_mux_bitmap_arb #( \
        .CHN   ($bits(iVld_)), \
        .WIDTH ($bits(oDat_)), \
        .MODE  (MODE_) \
    ) UnitName ( \
        .clk   (clk_), \
        .rst   (rst_), \
        .iVld  (iVld_), \
        .iDat  (iDat_), \
        .iMask (iMask_), \
        .oRdy  (oRdy_), \
        .oVld  (oVld_), \
        .oDat  (oDat_), \
        .oSel  (oSel_), \
        .oIdx  (oIdx_), \
        .iRdy  (iRdy_) \
    );
`endif

// File: tb/tb_zion_mux_bitmap_arb.sv
// Bench for zion_mux_bitmap_arb: fixed and round-robin instances share stimulus
// and are compared each cycle against a behavioural arbitration model.
module tb_zion_mux_bitmap_arb;
    import zion_arb_pkg::*;

    localparam int CHN = 4;
    localparam int WIDTH = 8;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [CHN-1:0]   iVld;
    logic [CHN-1:0]   iMask;
    logic [CHN*WIDTH-1:0] iDat;
    logic             iRdy;

    logic [CHN-1:0]   ordy [2];
    logic             ovld [2];
    logic [WIDTH-1:0] odat [2];
    logic [CHN-1:0]   osel [2];
    logic [IW-1:0]    oidx [2];

    // Model state, index 0 = fixed instance, 1 = round-robin instance
    logic             m_vld [2];
    logic [WIDTH-1:0] m_dat [2];
    logic [CHN-1:0]   m_sel [2];
    int               m_idx [2];
    int               m_ptr [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    zion_mux_bitmap_arb #(.CHN(CHN), .WIDTH(WIDTH), .MODE(ARB_FIXED)) u_fix (
        .clk(clk), .rst(rst), .iVld(iVld), .iDat(iDat), .iMask(iMask),
        .oRdy(ordy[0]), .oVld(ovld[0]), .oDat(odat[0]), .oSel(osel[0]), .oIdx(oidx[0]),
        .iRdy(iRdy)
    );

    zion_mux_bitmap_arb #(.CHN(CHN), .WIDTH(WIDTH), .MODE(ARB_RR)) u_rr (
        .clk(clk), .rst(rst), .iVld(iVld), .iDat(iDat), .iMask(iMask),
        .oRdy(ordy[1]), .oVld(ovld[1]), .oDat(odat[1]), .oSel(osel[1]), .oIdx(oidx[1]),
        .iRdy(iRdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requesting channel that wins: scan upward from the start point, wrapping.
    function automatic int winner(input int m);
        int start;
        logic [CHN-1:0] req;
        req = iVld & iMask;
        start = (m == 1) ? m_ptr[1] : 0;
        for (int k = 0; k < CHN; k++) begin
            if (req[(start + k) % CHN]) return (start + k) % CHN;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_vld[m] = 1'b0; m_dat[m] = '0; m_sel[m] = '0; m_idx[m] = 0; m_ptr[m] = 0;
        end
    endfunction

    // Called just after a negedge with inputs already applied; returns after the next negedge.
    task automatic cycle();
        int g [2];
        logic ld [2];
        #1;
        for (int m = 0; m < 2; m++) begin
            g[m]  = winner(m);
            ld[m] = !m_vld[m] || iRdy;
            chk(m == 0 ? "fix_oRdy" : "rr_oRdy", 32'(ordy[m]),
                (!rst && ld[m] && g[m] >= 0) ? (32'd1 << g[m]) : 32'd0);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (ld[m]) begin
                    if (g[m] >= 0) begin
                        m_vld[m] = 1'b1;
                        m_dat[m] = iDat[g[m]*WIDTH +: WIDTH];
                        m_sel[m] = CHN'(1) << g[m];
                        m_idx[m] = g[m];
                        m_ptr[m] = (g[m] + 1) % CHN;
                    end else begin
                        m_vld[m] = 1'b0;
                    end
                end
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            chk(m == 0 ? "fix_oVld" : "rr_oVld", 32'(ovld[m]), 32'(m_vld[m]));
            chk(m == 0 ? "fix_oDat" : "rr_oDat", 32'(odat[m]), 32'(m_dat[m]));
            chk(m == 0 ? "fix_oSel" : "rr_oSel", 32'(osel[m]), 32'(m_sel[m]));
            chk(m == 0 ? "fix_oIdx" : "rr_oIdx", 32'(oidx[m]), 32'(m_idx[m]));
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; iVld = '0; iMask = '1; iDat = '0; iRdy = 1'b1;
        model_reset();
        @(negedge clk);

        // Reset then idle
        cycle(); cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("idle_oVld", 32'(ovld[1]), 32'd0);

        // Fixed priority picks the lowest requester
        iVld = 4'b1010; iDat = 32'h33_00_11_00;
        cycle();
        chk("fix_first", 32'(odat[0]), 32'h11);
        chk("fix_first_idx", 32'(oidx[0]), 32'd1);
        iVld = 4'b1000;
        cycle();
        chk("fix_second", 32'(odat[0]), 32'h33);
        chk("fix_second_idx", 32'(oidx[0]), 32'd3);

        // Round-robin rotation with all channels requesting
        iVld = 4'b1111; iDat = 32'h44_33_22_11;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_rotate", 32'(oidx[1]), 32'(k % CHN));
        end

        // Backpressure holds the word and the pointer
        iDat = 32'h22_22_22_22;
        cycle();
        iRdy = 1'b0; iDat = 32'h99_88_77_66;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_dat", 32'(odat[1]), 32'h22);
            chk("stall_rdy", 32'(ordy[1]), 32'd0);
        end
        iRdy = 1'b1;
        cycle();
        chk("release_idx", 32'(oidx[1]), 32'd2);

        // Mask and skip with the pointer parked at 1
        rst = 1'b1; cycle(); rst = 1'b0;
        iVld = 4'b0001; cycle();
        iMask = 4'b1001; iVld = 4'b1111;
        cycle(); chk("mask_g3a", 32'(oidx[1]), 32'd3);
        cycle(); chk("mask_g0", 32'(oidx[1]), 32'd0);
        cycle(); chk("mask_g3b", 32'(oidx[1]), 32'd3);
        iMask = 4'b0000;
        cycle(); cycle();
        chk("mask_drain", 32'(ovld[1]), 32'd0);

        // Reset during a stall drops the word and rewinds the pointer
        iMask = 4'b1111; iVld = 4'b1111;
        cycle(); cycle();
        iRdy = 1'b0; cycle(); cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rst_stall_vld", 32'(ovld[1]), 32'd0);
        iRdy = 1'b1; cycle();
        chk("rst_first_rr", 32'(oidx[1]), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            iVld  = CHN'($urandom);
            iMask = ($urandom_range(0, 3) == 0) ? CHN'($urandom) : '1;
            iDat  = $urandom;
            iRdy  = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
